// File: rtl/sram_arbiter.sv
// Two-port (fetch I / data D) arbiter that sequences one access at a time onto a
// single-port SRAM bus, alternating grants when both ports request together.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | sample requests, grant one port, latch its access
// S_READ     | en/re held READ_CYCLES cycles, data captured on last one
// S_WR_SETUP | en=1, we=0, address/data/mask presented
// S_WR_PULSE | we=1 for WRITE_CYCLES cycles
// S_WR_HOLD  | we dropped, address/data/mask still held
// S_RESP     | bus idle, granted port's ack pulses for this cycle
module sram_arbiter #(
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [19:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [19:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    input  logic [31:0] io_sram_dout,
    output logic [19:0] io_sram_addr,
    output logic [31:0] io_sram_din,
    output logic        io_sram_en,
    output logic        io_sram_re,
    output logic        io_sram_we,
    output logic [3:0]  io_sram_wmask
);

    localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] READ_LOAD  = CW'(READ_CYCLES - 1);
    localparam logic [CW-1:0] WRITE_LOAD = CW'(WRITE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_d;
    logic          r_port_d;
    logic          r_i_ack;
    logic          r_d_ack;
    logic [31:0]   r_i_rdata;
    logic [31:0]   r_d_rdata;
    logic [19:0]   r_addr;
    logic [31:0]   r_din;
    logic          r_en;
    logic          r_re;
    logic          r_we;
    logic [3:0]    r_wmask;

    logic          w_grant_i;
    logic          w_grant_d;

    // I wins unless D is also requesting and I was the most recent grant.
    assign w_grant_i = i_req && (!d_req || r_last_d);
    assign w_grant_d = d_req && !w_grant_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last_d  <= 1'b1;
            r_port_d  <= 1'b0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_en      <= 1'b0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
            r_wmask   <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_i) begin
                        r_port_d <= 1'b0;
                        r_last_d <= 1'b0;
                        r_addr   <= i_addr;
                        r_wmask  <= '0;
                        r_en     <= 1'b1;
                        r_re     <= 1'b1;
                        r_cnt    <= READ_LOAD;
                        r_state  <= S_READ;
                    end else if (w_grant_d) begin
                        r_port_d <= 1'b1;
                        r_last_d <= 1'b1;
                        r_addr   <= d_addr;
                        r_din    <= d_wdata;
                        r_en     <= 1'b1;
                        if (d_we) begin
                            r_wmask <= d_wmask;
                            r_state <= S_WR_SETUP;
                        end else begin
                            r_wmask <= '0;
                            r_re    <= 1'b1;
                            r_cnt   <= READ_LOAD;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_cnt == '0) begin
                        r_en <= 1'b0;
                        r_re <= 1'b0;
                        if (r_port_d) begin
                            r_d_rdata <= io_sram_dout;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_i_rdata <= io_sram_dout;
                            r_i_ack   <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    r_we    <= 1'b1;
                    r_cnt   <= WRITE_LOAD;
                    r_state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (r_cnt == '0) begin
                        r_we    <= 1'b0;
                        r_state <= S_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WR_HOLD: begin
                    r_en    <= 1'b0;
                    r_d_ack <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_en    <= 1'b0;
                    r_re    <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_ack         = r_i_ack;
    assign i_rdata       = r_i_rdata;
    assign d_ack         = r_d_ack;
    assign d_rdata       = r_d_rdata;
    assign io_sram_addr  = r_addr;
    assign io_sram_din   = r_din;
    assign io_sram_en    = r_en;
    assign io_sram_re    = r_re;
    assign io_sram_we    = r_we;
    assign io_sram_wmask = r_wmask;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level reference model with cycle offsets,
// a behavioural SRAM on the bus, directed scenarios and random traffic.
module tb_sram_arbiter;

    localparam int RC = 2;
    localparam int WC = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [19:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [19:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] io_sram_dout;
    logic [19:0] io_sram_addr;
    logic [31:0] io_sram_din;
    logic        io_sram_en;
    logic        io_sram_re;
    logic        io_sram_we;
    logic [3:0]  io_sram_wmask;

    always #5 clk = ~clk;

    sram_arbiter #(.READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_ack(d_ack), .d_rdata(d_rdata),
        .io_sram_dout(io_sram_dout), .io_sram_addr(io_sram_addr),
        .io_sram_din(io_sram_din), .io_sram_en(io_sram_en), .io_sram_re(io_sram_re),
        .io_sram_we(io_sram_we), .io_sram_wmask(io_sram_wmask)
    );

    typedef struct packed {
        logic        we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // Behavioural SRAM: combinational read, masked write on en&we at the clock edge.
    logic [31:0] sram_mem [0:255];
    bit          sram_init = 0;
    assign io_sram_dout = sram_mem[io_sram_addr[7:0]];

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
            sram_init <= 1;
        end else if (io_sram_en && io_sram_we) begin
            sram_mem[io_sram_addr[7:0]] <= merge(sram_mem[io_sram_addr[7:0]], io_sram_din, io_sram_wmask);
        end
    end

    // Reference model: one transaction at a time, grant cycle m_s, outputs by offset.
    logic [31:0] ref_mem [0:255];
    bit          ref_init = 0;
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_s = 0;
    bit          m_port_d = 0;
    bit          m_we = 0;
    bit          m_last_d = 1;
    logic [19:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdexp = '0;
    logic [3:0]  m_mask = '0;
    bit          rst_flag = 0;

    always @(posedge clk) begin
        bit         busy;
        bit         pd;
        logic [7:0] idx;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] <= init_word(i);
            ref_init <= 1;
        end
        rst_flag <= reset;
        if (reset) begin
            m_busy   <= 0;
            m_last_d <= 1;
        end else begin
            busy = m_busy;
            if (busy && (cyc - m_s) >= (m_we ? WC + 4 : RC + 2)) busy = 0;
            if (!busy && (i_req || d_req)) begin
                pd = !(i_req && (!d_req || m_last_d));
                busy = 1;
                m_s      <= cyc;
                m_port_d <= pd;
                m_last_d <= pd;
                if (pd) begin
                    idx = d_addr[7:0];
                    m_we    <= d_we;
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                    m_mask  <= d_wmask;
                    if (d_we) ref_mem[idx] <= merge(ref_mem[idx], d_wdata, d_wmask);
                    else      m_rdexp <= ref_mem[idx];
                end else begin
                    m_we    <= 0;
                    m_addr  <= i_addr;
                    m_rdexp <= ref_mem[i_addr[7:0]];
                end
            end
            m_busy <= busy;
        end
        cyc <= cyc + 1;
    end

    // Checker and requesters, both on the falling edge.
    req_t        q_i[$];
    req_t        q_d[$];
    bit          ack_log[$];
    bit          i_out = 0, i_done = 0, d_out = 0, d_done = 0;
    logic [31:0] exp_d_rdata = '0;

    always @(negedge clk) begin
        int   k;
        logic e_en, e_re, e_we, e_ia, e_da;
        req_t t;
        k = cyc - m_s;
        e_en = 0; e_re = 0; e_we = 0; e_ia = 0; e_da = 0;
        if (rst_flag) begin
            check("rst_addr",    {12'b0, io_sram_addr}, 32'h0);
            check("rst_din",     io_sram_din, 32'h0);
            check("rst_wmask",   {28'b0, io_sram_wmask}, 32'h0);
            check("rst_i_rdata", i_rdata, 32'h0);
            check("rst_d_rdata", d_rdata, 32'h0);
            exp_d_rdata = '0;
        end
        if (m_busy && !m_we) begin
            e_en = (k >= 1 && k <= RC);
            e_re = e_en;
            e_ia = !m_port_d && (k == RC + 1);
            e_da = m_port_d && (k == RC + 1);
        end else if (m_busy) begin
            e_en = (k >= 1 && k <= WC + 2);
            e_we = (k >= 2 && k <= WC + 1);
            e_da = (k == WC + 3);
        end
        check("en_re_we_iack_dack", {27'b0, io_sram_en, io_sram_re, io_sram_we, i_ack, d_ack},
              {27'b0, e_en, e_re, e_we, e_ia, e_da});
        if (e_en) begin
            check("addr",  {12'b0, io_sram_addr}, {12'b0, m_addr});
            check("wmask", {28'b0, io_sram_wmask}, {28'b0, (m_we ? m_mask : 4'b0000)});
            if (m_we) check("din", io_sram_din, m_wdata);
        end
        if (e_ia) check("i_rdata", i_rdata, m_rdexp);
        if (e_da) begin
            if (m_we) check("d_rdata_hold", d_rdata, exp_d_rdata);
            else begin
                check("d_rdata", d_rdata, m_rdexp);
                exp_d_rdata = m_rdexp;
            end
        end
        if (i_ack) ack_log.push_back(1'b0);
        if (d_ack) ack_log.push_back(1'b1);

        if (i_done) begin
            i_req = 0; i_out = 0; i_done = 0;
        end else if (e_ia) i_done = 1;
        if (!i_out && q_i.size() > 0) begin
            t = q_i.pop_front();
            i_addr = t.addr; i_req = 1; i_out = 1;
        end
        if (d_done) begin
            d_req = 0; d_out = 0; d_done = 0;
        end else if (e_da) d_done = 1;
        if (!d_out && q_d.size() > 0) begin
            t = q_d.pop_front();
            d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_wmask = t.mask;
            d_req = 1; d_out = 1;
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = (q_i.size() == 0) && (q_d.size() == 0) && !i_out && !d_out && !m_busy;
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    task automatic push_i(input logic [19:0] a);
        q_i.push_back('{we: 1'b0, addr: a, wdata: 32'h0, mask: 4'h0});
    endtask

    task automatic push_d(input logic we, input logic [19:0] a, input logic [31:0] w,
                          input logic [3:0] m);
        q_d.push_back('{we: we, addr: a, wdata: w, mask: m});
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
    endtask

    initial begin
        int  base;
        bit  hit;
        repeat (3) @(negedge clk);
        reset = 0;

        push_i(20'h00010);
        wait_drain("drain_single_read", 100);

        push_d(1'b1, 20'h00020, 32'h12345678, 4'b0011);
        wait_drain("drain_byte_write", 100);
        push_i(20'h00020);
        wait_drain("drain_readback", 100);

        push_d(1'b1, 20'h00030, 32'hCAFEF00D, 4'b0000);
        wait_drain("drain_zero_mask", 100);
        push_d(1'b0, 20'h00030, 32'h0, 4'b0000);
        wait_drain("drain_zero_mask_read", 100);

        pulse_reset();
        base = ack_log.size();
        for (int j = 0; j < 3; j++) begin
            push_i(20'(32'h100 + j));
            push_d(1'b0, 20'(32'h200 + j), 32'h0, 4'h0);
        end
        wait_drain("drain_conflict", 200);
        check("conflict_acks", 32'(ack_log.size() - base), 32'd6);
        for (int j = 0; j < 6 && base + j < ack_log.size(); j++)
            check("conflict_order", {31'b0, ack_log[base + j]}, 32'(j % 2));

        base = ack_log.size();
        for (int j = 0; j < 6; j++) push_d(1'b0, 20'(32'h40 + j), 32'h0, 4'h0);
        for (int j = 0; j < 3; j++) push_i(20'(32'h80 + j));
        wait_drain("drain_d_stream", 300);
        check("d_stream_acks", 32'(ack_log.size() - base), 32'd9);
        for (int j = 0; j < 6 && base + j < ack_log.size(); j++)
            check("d_stream_order", {31'b0, ack_log[base + j]}, 32'(j % 2));

        base = ack_log.size();
        hit = 0;
        push_i(20'h00044);
        for (int n = 0; n < 50 && !hit; n++) begin
            @(negedge clk);
            hit = m_busy && !m_we && (cyc - m_s == 1);
        end
        check("reached_read_cycle1", {31'b0, hit}, 32'd1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        wait_drain("drain_after_reset", 100);
        check("reset_read_acks", 32'(ack_log.size() - base), 32'd1);

        for (int r = 0; r < 300; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) push_i(20'($urandom));
            else push_d(1'($urandom_range(0, 1)), 20'($urandom), $urandom, 4'($urandom));
        end
        wait_drain("drain_random", 5000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
